// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package ex_mdu_pkg;

   // Operation select: bit 1 picks divide, bit 0 picks unsigned.
   typedef enum logic [1:0] {
      MDU_OP_MULT  = 2'b00,
      MDU_OP_MULTU = 2'b01,
      MDU_OP_DIV   = 2'b10,
      MDU_OP_DIVU  = 2'b11
   } mdu_op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_RUN  = 2'b01,
      MDU_ZERO = 2'b10,
      MDU_DONE = 2'b11
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input mdu_op_e op);
      return !op[0];
   endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative radix-2 multiply/divide unit returning {HI, LO}.
// Handshake: start_i is taken only in IDLE (and only when annul_i is low);
// busy_o stays high from the accept until the result is registered, and
// ready_o pulses for exactly one cycle with result_o/div_by_zero_o valid.
// There is no backpressure: the result must be consumed on the pulse.
// Datapath: one 2*WIDTH shift register holds {acc_hi, multiplier} for
// multiply or {remainder, dividend/quotient} for divide, stepped once
// per cycle on unsigned magnitudes; signs are restored when finishing.
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_by_zero_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mdu_state_e           state_q, state_d;
   mdu_op_e              op_q, op_d;
   logic [2*WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sa_q, sa_d;
   logic                 sb_q, sb_d;
   logic                 dbz_q, dbz_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;
   logic                 dbz_out_q, dbz_out_d;

   // Per-step datapath values.
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH+1:0]     div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_next;
   logic                 unused_div_bit;

   // Sign-corrected results.
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;
   logic [2*WIDTH-1:0]   final_res;

   // Accept-time decode of the incoming request.
   mdu_op_e              op_in;
   logic                 sgn_in;
   logic                 sa_in;
   logic                 sb_in;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;

   // Two's-complement magnitude; the most negative value maps to itself,
   // which read unsigned is exactly 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   // Decode the request and build operand magnitudes.
   always_comb begin
      op_in  = mdu_op_e'(op_i);
      sgn_in = op_is_signed(op_in);
      sa_in  = sgn_in & opdata1_i[WIDTH-1];
      sb_in  = sgn_in & opdata2_i[WIDTH-1];
      mag_a  = magnitude(opdata1_i, sa_in);
      mag_b  = magnitude(opdata2_i, sb_in);
   end

   // One shift-add multiply step and one restoring divide step.
   always_comb begin
      mul_sum        = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + (sr_q[0] ? {1'b0, b_q} : '0);
      mul_next       = {mul_sum, sr_q[WIDTH-1:1]};
      rem_sh         = sr_q[2*WIDTH-1:WIDTH-1];
      div_diff       = {1'b0, rem_sh} - {2'b00, b_q};
      div_ge         = !div_diff[WIDTH+1];
      unused_div_bit = div_diff[WIDTH];
      div_next       = div_ge ? {div_diff[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1}
                              : {rem_sh[WIDTH-1:0],   sr_q[WIDTH-2:0], 1'b0};
   end

   // Restore signs on the magnitude result.
   always_comb begin
      prod_fix  = (sa_q ^ sb_q) ? (~sr_q + 1'b1) : sr_q;
      quo_fix   = (sa_q ^ sb_q) ? (~sr_q[WIDTH-1:0] + 1'b1) : sr_q[WIDTH-1:0];
      rem_fix   = sa_q ? (~sr_q[2*WIDTH-1:WIDTH] + 1'b1) : sr_q[2*WIDTH-1:WIDTH];
      final_res = op_is_div(op_q) ? {rem_fix, quo_fix} : prod_fix;
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sr_d      = sr_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dbz_d     = dbz_q;
      result_d  = result_q;
      ready_d   = 1'b0;
      dbz_out_d = 1'b0;
      case (state_q)
         MDU_IDLE: begin
            if (start_i && !annul_i) begin
               op_d  = op_in;
               sa_d  = sa_in;
               sb_d  = sb_in;
               cnt_d = '0;
               dbz_d = 1'b0;
               if (op_is_div(op_in)) begin
                  sr_d    = {{WIDTH{1'b0}}, mag_a};
                  b_d     = mag_b;
                  state_d = (opdata2_i == '0) ? MDU_ZERO : MDU_RUN;
               end else begin
                  sr_d    = {{WIDTH{1'b0}}, mag_b};
                  b_d     = mag_a;
                  state_d = MDU_RUN;
               end
            end
         end
         MDU_RUN: begin
            if (annul_i) begin
               state_d = MDU_IDLE;
            end else begin
               sr_d  = op_is_div(op_q) ? div_next : mul_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_d = MDU_DONE;
               end
            end
         end
         MDU_ZERO: begin
            if (annul_i) begin
               state_d = MDU_IDLE;
            end else begin
               sr_d    = '0;
               dbz_d   = 1'b1;
               state_d = MDU_DONE;
            end
         end
         MDU_DONE: begin
            result_d  = dbz_q ? '0 : final_res;
            ready_d   = 1'b1;
            dbz_out_d = dbz_q;
            state_d   = MDU_IDLE;
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   // State, datapath and registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MDU_IDLE;
         op_q      <= MDU_OP_MULT;
         sr_q      <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         dbz_q     <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sr_q      <= sr_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         dbz_q     <= dbz_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   assign result_o      = result_q;
   assign ready_o       = ready_q;
   assign div_by_zero_o = dbz_out_q;
   assign busy_o        = (state_q != MDU_IDLE);

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (WIDTH=32).
module tb_ex_mdu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          annul_i;
   logic [1:0]    op_i;
   logic [W-1:0]  opdata1_i;
   logic [W-1:0]  opdata2_i;
   logic [2*W-1:0] result_o;
   logic          ready_o;
   logic          busy_o;
   logic          div_by_zero_o;

   int checks = 0;
   int failures = 0;

   ex_mdu #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .annul_i       (annul_i),
      .op_i          (op_i),
      .opdata1_i     (opdata1_i),
      .opdata2_i     (opdata2_i),
      .result_o      (result_o),
      .ready_o       (ready_o),
      .busy_o        (busy_o),
      .div_by_zero_o (div_by_zero_o)
   );

   // Clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp_res;
      logic           exp_dbz;
   } vec_t;

   vec_t vt [12];
   logic [2*W-1:0] exp_q [$];

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on 64-bit values.
   function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'b0, a};
      longint unsigned ub = {32'b0, b};
      longint          sq, sr;
      longint unsigned uq, ur;
      logic [2*W-1:0]  r;
      r = '0;
      case (op)
         2'b00: r = sa * sb;
         2'b01: r = ua * ub;
         2'b10: if (b != 0) begin
            sq = sa / sb;
            sr = sa % sb;
            r  = {sr[W-1:0], sq[W-1:0]};
         end
         default: if (b != 0) begin
            uq = ua / ub;
            ur = ua % ub;
            r  = {ur[W-1:0], uq[W-1:0]};
         end
      endcase
      return r;
   endfunction

   // Driver: called at a negedge; launches one op and waits for ready_o.
   // lat counts clock edges after the accepting edge until ready_o is seen.
   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] res, output logic dbz,
                        output int lat, output int busy_cyc);
      int k;
      start_i   = 1'b1;
      op_i      = op;
      opdata1_i = a;
      opdata2_i = b;
      @(negedge clk);
      start_i  = 1'b0;
      k        = 0;
      busy_cyc = 0;
      while (!ready_o && k < 200) begin
         if (busy_o) busy_cyc++;
         @(negedge clk);
         k++;
      end
      if (!ready_o) begin
         failures++;
         checks++;
         $display("FAIL timeout: no ready_o within %0d cycles (op=%0d)", k, op);
      end
      res = result_o;
      dbz = div_by_zero_o;
      lat = k;
   endtask

   logic [2*W-1:0] res;
   logic           dbz;
   int             lat;
   int             bcyc;

   initial begin
      logic [1:0]     rop;
      logic [W-1:0]   ra, rb;
      logic [2*W-1:0] e;
      int             pulses;
      int             ready_at;
      logic [2*W-1:0] pulse_res;

      vt[0]  = '{2'b11, 32'd100,        32'd7,        {32'd2, 32'd14},                 1'b0};
      vt[1]  = '{2'b10, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},    1'b0};
      vt[2]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF, {32'h0, 32'h80000000},           1'b0};
      vt[3]  = '{2'b00, 32'hFFFFFFFD,   32'd5,        64'hFFFFFFFF_FFFFFFF1,           1'b0};
      vt[4]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'hFFFFFFFE_00000001,           1'b0};
      vt[5]  = '{2'b10, 32'd5,          32'd0,        64'h0,                           1'b1};
      vt[6]  = '{2'b11, 32'd7,          32'd0,        64'h0,                           1'b1};
      vt[7]  = '{2'b00, 32'h80000000,   32'h80000000, 64'h40000000_00000000,           1'b0};
      vt[8]  = '{2'b10, 32'd7,          32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},           1'b0};
      vt[9]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h1,                           1'b0};
      vt[10] = '{2'b11, 32'hFFFFFFFF,   32'd1,        {32'h0, 32'hFFFFFFFF},           1'b0};
      vt[11] = '{2'b11, 32'd3,          32'd10,       {32'd3, 32'd0},                  1'b0};

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00;
      opdata1_i = '0; opdata2_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("reset result", result_o, 64'h0);
      chk("reset ready", {63'b0, ready_o}, 64'h0);
      chk("reset busy", {63'b0, busy_o}, 64'h0);
      chk("reset dbz", {63'b0, div_by_zero_o}, 64'h0);

      // Table vectors, issued back-to-back.
      for (int i = 0; i < 12; i++) begin
         do_op(vt[i].op, vt[i].a, vt[i].b, res, dbz, lat, bcyc);
         chk($sformatf("vec%0d result", i), res, vt[i].exp_res);
         chk($sformatf("vec%0d dbz", i), {63'b0, dbz}, {63'b0, vt[i].exp_dbz});
         chk($sformatf("vec%0d latency", i), 64'(lat), vt[i].exp_dbz ? 64'd2 : 64'd33);
         chk($sformatf("vec%0d busy cycles", i), 64'(bcyc), vt[i].exp_dbz ? 64'd2 : 64'd33);
      end
      // Cycle after the pulse: flags drop, result holds.
      @(negedge clk);
      chk("post ready", {63'b0, ready_o}, 64'h0);
      chk("post dbz", {63'b0, div_by_zero_o}, 64'h0);
      chk("post hold", result_o, vt[11].exp_res);

      // Known result, then annul a DIVU at iteration 10.
      do_op(2'b01, 32'd6, 32'd7, res, dbz, lat, bcyc);
      chk("pre-annul mul", res, 64'd42);
      start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd100; opdata2_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul busy", {63'b0, busy_o}, 64'h0);
      chk("annul ready", {63'b0, ready_o}, 64'h0);
      chk("annul result hold", result_o, 64'd42);
      // Start in the following cycle is accepted.
      do_op(2'b11, 32'd100, 32'd7, res, dbz, lat, bcyc);
      chk("after-annul result", res, {32'd2, 32'd14});
      chk("after-annul latency", 64'(lat), 64'd33);

      // annul_i in IDLE blocks the accept.
      start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd3; opdata2_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      chk("idle annul busy", {63'b0, busy_o}, 64'h0);

      // annul_i in ZERO: no pulse, no flag.
      start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd5; opdata2_i = 32'd0;
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      chk("zero annul busy", {63'b0, busy_o}, 64'h0);
      chk("zero annul ready", {63'b0, ready_o}, 64'h0);
      chk("zero annul dbz", {63'b0, div_by_zero_o}, 64'h0);
      chk("zero annul hold", result_o, {32'd2, 32'd14});

      // annul_i in DONE is ignored.
      start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd9; opdata2_i = 32'd9;
      @(negedge clk);
      start_i = 1'b0;
      repeat (32) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      chk("done annul ready", {63'b0, ready_o}, 64'h1);
      chk("done annul result", result_o, 64'd81);

      // start_i pulsed during RUN is ignored.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd6; opdata2_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      pulses = 0; ready_at = -1; pulse_res = '0;
      for (int k = 0; k < 80; k++) begin
         if (k == 5) begin
            start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd100; opdata2_i = 32'd7;
         end
         if (k == 6) start_i = 1'b0;
         if (ready_o) begin
            pulses++;
            ready_at = k;
            pulse_res = result_o;
         end
         @(negedge clk);
      end
      chk("busy-start pulses", 64'(pulses), 64'd1);
      chk("busy-start latency", 64'(ready_at), 64'd33);
      chk("busy-start result", pulse_res, 64'd42);

      // Reset mid-RUN.
      start_i = 1'b1; op_i = 2'b11; opdata1_i = 32'd100; opdata2_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst result", result_o, 64'h0);
      chk("midrst ready", {63'b0, ready_o}, 64'h0);
      chk("midrst busy", {63'b0, busy_o}, 64'h0);
      chk("midrst dbz", {63'b0, div_by_zero_o}, 64'h0);
      do_op(2'b01, 32'd6, 32'd7, res, dbz, lat, bcyc);
      chk("midrst mul", res, 64'd42);
      chk("midrst mul latency", 64'(lat), 64'd33);

      // Randomized ops against the model, through an expected queue.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom();
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            default: rb = $urandom();
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
         exp_q.push_back(model(rop, ra, rb));
         do_op(rop, ra, rb, res, dbz, lat, bcyc);
         e = exp_q.pop_front();
         chk($sformatf("rand%0d op%0d %h/%h result", i, rop, ra, rb), res, e);
         chk($sformatf("rand%0d dbz", i), {63'b0, dbz}, {63'b0, (rop[1] && rb == 0)});
         chk($sformatf("rand%0d latency", i), 64'(lat), (rop[1] && rb == 0) ? 64'd2 : 64'd33);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
